// File: rtl/median_window_scheduler.sv
// median_window_scheduler: walks median-filter window origins in raster order and writes each
// result to the output frame buffer. Define SCHED_WATCHDOG_EN to add the RUN/WRITE watchdog.
module median_window_scheduler #(
    parameter int unsigned WINDOW_SIZE = 3,
    parameter int unsigned DATA_WIDTH  = 24,
    parameter int unsigned BUS_WIDTH   = 32,
    parameter int unsigned IMG_WIDTH   = 512,
    parameter int unsigned IMG_HEIGHT  = 512,
    parameter int unsigned OUT_BASE    = 0,
    parameter int unsigned WDOG_LIMIT  = 1024
) (
    input  logic                  Sched_CLK,
    input  logic                  Sched_RST,
    input  logic                  Sched_START,
    output logic                  Sched_BUSY,
    output logic                  Sched_DONE,
    output logic [BUS_WIDTH-1:0]  Sched_COUNT,
    output logic                  Sched_FILTEN,
    output logic [BUS_WIDTH-1:0]  Sched_sROW,
    output logic [BUS_WIDTH-1:0]  Sched_sCOL,
    input  logic [DATA_WIDTH-1:0] Sched_FILTOUT,
    input  logic                  Sched_FILTDRDY,
    output logic [BUS_WIDTH-1:0]  Sched_WRADDR,
    output logic [DATA_WIDTH-1:0] Sched_WRDATA,
    output logic                  Sched_WRREQ,
    input  logic                  Sched_WRACK,
    output logic                  Sched_ERR
);

    // state | meaning
    // IDLE  | waiting for Sched_START
    // SETUP | origin presented on sROW/sCOL, FILTEN low for one cycle
    // RUN   | FILTEN high, waiting for FILTDRDY
    // WRITE | WRREQ high with address/data held, waiting for WRACK
    // DONE  | one-cycle DONE pulse, then back to IDLE

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_WRITE, S_DONE} state_t;

    localparam logic [BUS_WIDTH-1:0] HALF     = BUS_WIDTH'(WINDOW_SIZE / 2);
    localparam logic [BUS_WIDTH-1:0] COL_LAST = BUS_WIDTH'(IMG_WIDTH - WINDOW_SIZE);
    localparam logic [BUS_WIDTH-1:0] ROW_LAST = BUS_WIDTH'(IMG_HEIGHT - WINDOW_SIZE);
    localparam logic [BUS_WIDTH-1:0] WIDTH_W  = BUS_WIDTH'(IMG_WIDTH);
    localparam logic [BUS_WIDTH-1:0] BASE_W   = BUS_WIDTH'(OUT_BASE);

    state_t state;
    logic   wdog_trip;

`ifdef SCHED_WATCHDOG_EN
    localparam int unsigned    WD_W    = (WDOG_LIMIT > 1) ? $clog2(WDOG_LIMIT) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WDOG_LIMIT - 1);

    logic [WD_W-1:0] wdog_cnt;
    logic            err_q;

    // Down-counter reloaded on every entry to RUN or WRITE; terminal count means WDOG_LIMIT
    // cycles have been spent in the current state.
    assign wdog_trip = ((state == S_RUN) || (state == S_WRITE)) && (wdog_cnt == '0);
    assign Sched_ERR = err_q;

    always_ff @(posedge Sched_CLK) begin
        if (Sched_RST) begin
            wdog_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if ((state == S_IDLE) && Sched_START)
                err_q <= 1'b0;
            else if (wdog_trip)
                err_q <= 1'b1;

            if ((state == S_SETUP) || ((state == S_RUN) && Sched_FILTDRDY))
                wdog_cnt <= WD_LOAD;
            else if ((state == S_RUN) || (state == S_WRITE))
                wdog_cnt <= wdog_cnt - 1'b1;
        end
    end
`else
    assign wdog_trip = 1'b0;
    assign Sched_ERR = 1'b0;
`endif

    // sROW/sCOL double as the raster position registers.
    always_ff @(posedge Sched_CLK) begin
        if (Sched_RST) begin
            state        <= S_IDLE;
            Sched_BUSY   <= 1'b0;
            Sched_DONE   <= 1'b0;
            Sched_COUNT  <= '0;
            Sched_FILTEN <= 1'b0;
            Sched_sROW   <= '0;
            Sched_sCOL   <= '0;
            Sched_WRADDR <= '0;
            Sched_WRDATA <= '0;
            Sched_WRREQ  <= 1'b0;
        end else begin
            Sched_DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Sched_START) begin
                        state       <= S_SETUP;
                        Sched_BUSY  <= 1'b1;
                        Sched_COUNT <= '0;
                        Sched_sROW  <= '0;
                        Sched_sCOL  <= '0;
                    end
                end
                S_SETUP: begin
                    state        <= S_RUN;
                    Sched_FILTEN <= 1'b1;
                end
                S_RUN: begin
                    if (wdog_trip) begin
                        state        <= S_IDLE;
                        Sched_BUSY   <= 1'b0;
                        Sched_FILTEN <= 1'b0;
                    end else if (Sched_FILTDRDY) begin
                        state        <= S_WRITE;
                        Sched_FILTEN <= 1'b0;
                        Sched_WRREQ  <= 1'b1;
                        Sched_WRDATA <= Sched_FILTOUT;
                        Sched_WRADDR <= BASE_W + (Sched_sROW + HALF) * WIDTH_W
                                        + (Sched_sCOL + HALF);
                    end
                end
                S_WRITE: begin
                    if (wdog_trip) begin
                        state       <= S_IDLE;
                        Sched_BUSY  <= 1'b0;
                        Sched_WRREQ <= 1'b0;
                    end else if (Sched_WRACK) begin
                        Sched_WRREQ <= 1'b0;
                        Sched_COUNT <= Sched_COUNT + 1'b1;
                        if (Sched_sCOL < COL_LAST) begin
                            Sched_sCOL <= Sched_sCOL + 1'b1;
                            state      <= S_SETUP;
                        end else if (Sched_sROW < ROW_LAST) begin
                            Sched_sCOL <= '0;
                            Sched_sROW <= Sched_sROW + 1'b1;
                            state      <= S_SETUP;
                        end else begin
                            state      <= S_DONE;
                            Sched_DONE <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    Sched_BUSY <= 1'b0;
                end
                default: begin
                    state        <= S_IDLE;
                    Sched_BUSY   <= 1'b0;
                    Sched_FILTEN <= 1'b0;
                    Sched_WRREQ  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_median_window_scheduler.sv
// Scoreboard bench for median_window_scheduler: a filter/frame-buffer model responds to the
// DUT, expected writes come from a raster-order origin model, a monitor checks each write.
module tb_median_window_scheduler;

    localparam int IW   = 4;
    localparam int IH   = 4;
    localparam int WS   = 3;
    localparam int BASE = 100;
    localparam int WDL  = 16;
    localparam int NWIN = (IW - WS + 1) * (IH - WS + 1);

    logic        clk = 1'b0;
    logic        rst, start;
    logic        busy, done, filten, wrreq, err;
    logic [31:0] count, srow, scol, wraddr;
    logic [23:0] filtout, wrdata;
    logic        filtdrdy, wrack;

    logic        start_b, busy_b, done_b, filten_b, wrreq_b, err_b, filtdrdy_b, wrack_b;
    logic [31:0] count_b, srow_b, scol_b, wraddr_b;
    logic [23:0] filtout_b, wrdata_b;

    always #5 clk = ~clk;

    median_window_scheduler #(
        .WINDOW_SIZE(WS), .DATA_WIDTH(24), .BUS_WIDTH(32), .IMG_WIDTH(IW),
        .IMG_HEIGHT(IH), .OUT_BASE(BASE), .WDOG_LIMIT(WDL)
    ) dut (
        .Sched_CLK(clk), .Sched_RST(rst), .Sched_START(start), .Sched_BUSY(busy),
        .Sched_DONE(done), .Sched_COUNT(count), .Sched_FILTEN(filten), .Sched_sROW(srow),
        .Sched_sCOL(scol), .Sched_FILTOUT(filtout), .Sched_FILTDRDY(filtdrdy),
        .Sched_WRADDR(wraddr), .Sched_WRDATA(wrdata), .Sched_WRREQ(wrreq),
        .Sched_WRACK(wrack), .Sched_ERR(err)
    );

    median_window_scheduler #(
        .WINDOW_SIZE(3), .DATA_WIDTH(24), .BUS_WIDTH(32), .IMG_WIDTH(3),
        .IMG_HEIGHT(3), .OUT_BASE(BASE), .WDOG_LIMIT(1024)
    ) dut_b (
        .Sched_CLK(clk), .Sched_RST(rst), .Sched_START(start_b), .Sched_BUSY(busy_b),
        .Sched_DONE(done_b), .Sched_COUNT(count_b), .Sched_FILTEN(filten_b),
        .Sched_sROW(srow_b), .Sched_sCOL(scol_b), .Sched_FILTOUT(filtout_b),
        .Sched_FILTDRDY(filtdrdy_b), .Sched_WRADDR(wraddr_b), .Sched_WRDATA(wrdata_b),
        .Sched_WRREQ(wrreq_b), .Sched_WRACK(wrack_b), .Sched_ERR(err_b)
    );

    int checks   = 0;
    int failures = 0;

    int unsigned exp_row[$];
    int unsigned exp_col[$];
    logic [31:0] exp_addr[$];
    logic [23:0] exp_data[$];

    // Environment knobs set by the stimulus process.
    int filt_delay_fixed = -1;
    int ack_delay_fixed  = -1;
    int filt_hold_from   = 99;
    bit fix_data         = 1'b0;
    bit stray_en         = 1'b0;

    int done_seen   = 0;
    int writes_seen = 0;
    int filten_hi   = 0;

    int          fcnt = -1, win_idx = 0, req_cycles = 0, ack_wait = 0;
    bit          filten_q = 1'b0;
    int unsigned cur_r = 0, cur_c = 0;
    logic [31:0] hold_addr, ea;
    logic [23:0] hold_data, ed;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push_origins();
        for (int r = 0; r <= IH - WS; r++)
            for (int c = 0; c <= IW - WS; c++) begin
                exp_row.push_back(r);
                exp_col.push_back(c);
            end
    endtask

    // Filter model, frame-buffer model and write monitor.
    initial begin : env
        filtdrdy = 1'b0;
        filtout  = '0;
        wrack    = 1'b0;
        forever begin
            @(negedge clk);
            filtdrdy = 1'b0;
            if (rst) begin
                fcnt = -1; filten_q = 1'b0; wrack = 1'b0; req_cycles = 0; win_idx = 0;
                continue;
            end
            if (done) done_seen++;
            if (!busy) win_idx = 0;
            if (!filten) fcnt = -1;

            if (filten && !filten_q) begin
                filten_hi = 0;
                chk("origin_queue_nonempty", exp_row.size() > 0, 1);
                if (exp_row.size() > 0) begin
                    cur_r = exp_row.pop_front();
                    cur_c = exp_col.pop_front();
                    chk("sROW", srow, cur_r);
                    chk("sCOL", scol, cur_c);
                end
                if (win_idx >= filt_hold_from)  fcnt = -1;
                else if (filt_delay_fixed >= 0) fcnt = filt_delay_fixed;
                else                            fcnt = $urandom_range(0, 4);
                win_idx++;
            end
            if (filten) filten_hi++;
            filten_q = filten;

            if (filten && fcnt == 0) begin
                filtdrdy = 1'b1;
                filtout  = fix_data ? 24'hABCDEF : 24'($urandom);
                exp_addr.push_back(32'(BASE + (cur_r + WS / 2) * IW + (cur_c + WS / 2)));
                exp_data.push_back(filtout);
                fcnt = -1;
            end else if (fcnt > 0) begin
                fcnt--;
            end else if (stray_en && !filten && $urandom_range(0, 1) == 1) begin
                filtdrdy = 1'b1;
                filtout  = 24'($urandom);
            end

            if (wrack) begin
                wrack = 1'b0;
                chk("WRREQ_drop_after_ack", wrreq, 0);
            end else if (wrreq || req_cycles > 0) begin
                if (req_cycles > 0) chk("WRREQ_held_until_ack", wrreq, 1);
                if (!wrreq) begin
                    req_cycles = 0;
                end else begin
                    if (req_cycles == 0) begin
                        hold_addr = wraddr;
                        hold_data = wrdata;
                        ack_wait  = (ack_delay_fixed >= 0) ? ack_delay_fixed
                                                           : $urandom_range(0, 3);
                    end else begin
                        chk("WRADDR_stable", wraddr, hold_addr);
                        chk("WRDATA_stable", wrdata, hold_data);
                    end
                    req_cycles++;
                    if (ack_wait == 0) begin
                        wrack = 1'b1;
                        chk("write_expected", exp_addr.size() > 0, 1);
                        if (exp_addr.size() > 0) begin
                            ea = exp_addr.pop_front();
                            ed = exp_data.pop_front();
                            chk("WRADDR", wraddr, ea);
                            chk("WRDATA", wrdata, ed);
                        end
                        writes_seen++;
                        req_cycles = 0;
                    end else begin
                        ack_wait--;
                    end
                end
            end
        end
    end

    task automatic run_frame(input bit pulse, input int exp_fe, input int exp_wr);
        int d0, w0, fe_hi, wr_hi;
        d0 = done_seen;
        w0 = writes_seen;
        push_origins();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("BUSY_after_start", busy, 1);
        chk("FILTEN_low_in_setup", filten, 0);
        cyc();
        chk("FILTEN_rise_latency", filten, 1);
        fe_hi = 1;
        wr_hi = 0;
        for (int i = 0; i < 600 && done_seen == d0; i++) begin
            if (pulse) start = (i % 7 == 3);
            cyc();
            if (wrreq)  wr_hi++;
            if (filten) fe_hi++;
        end
        start = 1'b0;
        chk("DONE_reached", done_seen > d0, 1);
        repeat (3) cyc();
        chk("COUNT_final", count, NWIN);
        chk("writes_in_frame", writes_seen - w0, NWIN);
        chk("DONE_pulses", done_seen - d0, 1);
        chk("BUSY_idle", busy, 0);
        chk("ERR_clear", err, 0);
        chk("scoreboard_empty", exp_addr.size() + exp_row.size(), 0);
        if (exp_fe >= 0) chk("FILTEN_high_cycles", fe_hi, exp_fe);
        if (exp_wr >= 0) chk("WRREQ_high_cycles", wr_hi, exp_wr);
    endtask

    initial begin : stim
        int d0, w0;
        logic [23:0] bdata;
        rst = 1'b1; start = 1'b0;
        start_b = 1'b0; filtdrdy_b = 1'b0; wrack_b = 1'b0; filtout_b = '0;
        repeat (3) cyc();
        chk("rst_BUSY", busy, 0);     chk("rst_DONE", done, 0);
        chk("rst_COUNT", count, 0);   chk("rst_FILTEN", filten, 0);
        chk("rst_sROW", srow, 0);     chk("rst_sCOL", scol, 0);
        chk("rst_WRADDR", wraddr, 0); chk("rst_WRDATA", wrdata, 0);
        chk("rst_WRREQ", wrreq, 0);   chk("rst_ERR", err, 0);
        chk("rst_b_BUSY", busy_b, 0);
        rst = 1'b0;
        cyc();

        // Fixed filter latency, immediate ack.
        filt_delay_fixed = 3; ack_delay_fixed = 0;
        run_frame(1'b0, NWIN * 4, NWIN);

        // Constant data with a slow frame buffer.
        filt_delay_fixed = -1; fix_data = 1'b1; ack_delay_fixed = 5;
        run_frame(1'b0, -1, NWIN * 6);

        // START while busy and stray FILTDRDY outside RUN.
        fix_data = 1'b0; ack_delay_fixed = -1; stray_en = 1'b1;
        run_frame(1'b1, -1, -1);
        stray_en = 1'b0;

        for (int f = 0; f < 3; f++) begin
            stray_en = ($urandom_range(0, 1) == 1);
            run_frame(1'b0, -1, -1);
        end
        stray_en = 1'b0;

        // Reset while the second window is in RUN.
        filt_hold_from = 1;
        d0 = done_seen; w0 = writes_seen;
        push_origins();
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 300 && !(writes_seen == w0 + 1 && filten); i++) cyc();
        chk("reached_window2_run", (writes_seen == w0 + 1) && filten, 1);
        rst = 1'b1;
        cyc();
        chk("abort_FILTEN", filten, 0); chk("abort_BUSY", busy, 0);
        chk("abort_COUNT", count, 0);   chk("abort_WRREQ", wrreq, 0);
        chk("abort_DONE", done, 0);
        rst = 1'b0;
        exp_row.delete(); exp_col.delete(); exp_addr.delete(); exp_data.delete();
        filt_hold_from = 99;
        repeat (10) cyc();
        chk("abort_no_write", writes_seen - w0, 1);
        chk("abort_no_DONE", done_seen - d0, 0);
        chk("abort_stays_idle", busy, 0);

        // 3x3 image: a single window.
        bdata = 24'($urandom);
        start_b = 1'b1; cyc(); start_b = 1'b0;
        for (int i = 0; i < 20 && !filten_b; i++) cyc();
        chk("b_FILTEN", filten_b, 1);
        chk("b_sROW", srow_b, 0);
        chk("b_sCOL", scol_b, 0);
        filtout_b = bdata; filtdrdy_b = 1'b1; cyc(); filtdrdy_b = 1'b0;
        chk("b_WRREQ", wrreq_b, 1);
        chk("b_WRADDR", wraddr_b, BASE + 4);
        chk("b_WRDATA", wrdata_b, bdata);
        wrack_b = 1'b1; cyc(); wrack_b = 1'b0;
        chk("b_WRREQ_drop", wrreq_b, 0);
        chk("b_DONE", done_b, 1);
        chk("b_COUNT", count_b, 1);
        cyc();
        chk("b_DONE_single", done_b, 0);
        chk("b_BUSY_idle", busy_b, 0);

        // Filter that never answers.
        filt_hold_from = 0;
        d0 = done_seen; w0 = writes_seen;
        push_origins();
        start = 1'b1; cyc(); start = 1'b0;
`ifdef SCHED_WATCHDOG_EN
        for (int i = 0; i < 100 && busy; i++) cyc();
        chk("wdog_BUSY_dropped", busy, 0);
        chk("wdog_FILTEN_cycles", filten_hi, WDL);
        repeat (3) cyc();
        chk("wdog_ERR_sticky", err, 1);
        chk("wdog_no_DONE", done_seen - d0, 0);
        chk("wdog_no_write", writes_seen - w0, 0);
        exp_row.delete(); exp_col.delete();
        filt_hold_from = 99;
        run_frame(1'b0, -1, -1);
`else
        repeat (50) cyc();
        chk("nowdog_BUSY", busy, 1);
        chk("nowdog_FILTEN", filten, 1);
        chk("nowdog_ERR", err, 0);
        chk("nowdog_no_DONE", done_seen - d0, 0);
        rst = 1'b1; cyc(); rst = 1'b0;
        exp_row.delete(); exp_col.delete();
        filt_hold_from = 99;
        cyc();
        chk("nowdog_reset_idle", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
